// File: rtl/nrisc_ula_seq_pkg.sv
// Shared constants for the registered NRISC ALU: opcodes, FSM states, flag bit indices.
package nrisc_ula_seq_pkg;

  localparam logic [3:0] ULA_ADD  = 4'd0;
  localparam logic [3:0] ULA_SUB  = 4'd1;
  localparam logic [3:0] ULA_AND  = 4'd2;
  localparam logic [3:0] ULA_NAND = 4'd3;
  localparam logic [3:0] ULA_OR   = 4'd4;
  localparam logic [3:0] ULA_XOR  = 4'd5;
  localparam logic [3:0] ULA_SHR  = 4'd6;
  localparam logic [3:0] ULA_ROTR = 4'd7;
  localparam logic [3:0] ULA_SAR  = 4'd8;
  localparam logic [3:0] ULA_SHL  = 4'd9;
  localparam logic [3:0] ULA_ROTL = 4'd10;
  localparam logic [3:0] ULA_MULL = 4'd11;
  localparam logic [3:0] ULA_MULH = 4'd12;
  localparam logic [3:0] ULA_DIVU = 4'd13;
  localparam logic [3:0] ULA_REMU = 4'd14;
  localparam logic [3:0] ULA_RSVD = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } ula_state_t;

  localparam int FLAG_MINUS = 2;
  localparam int FLAG_ZERO  = 1;
  localparam int FLAG_CARRY = 0;

  // True for the opcodes served by the iterative multiply/divide engine.
  function automatic logic is_muldiv(input logic [3:0] op);
    return (op == ULA_MULL) || (op == ULA_MULH) || (op == ULA_DIVU) || (op == ULA_REMU);
  endfunction

  // Minus flag applies only to the signed-meaningful results.
  function automatic logic minus_op(input logic [3:0] op);
    return (op == ULA_ADD) || (op == ULA_SUB) || (op == ULA_SAR) || (op == ULA_MULL);
  endfunction

endpackage

// File: rtl/nrisc_ula_muldiv.sv
// Iterative unsigned multiply / divide engine, one result bit per clock.
// hi/lo form a double-width shift register: {acc, multiplier} for mul,
// {remainder, dividend->quotient} for div. Results are offered from the
// next-state values so the owner can register them on the final step edge.
module nrisc_ula_muldiv
  import nrisc_ula_seq_pkg::*;
#(
  parameter int TAM = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [3:0]     op,
  input  logic [TAM-1:0] a,
  input  logic [TAM-1:0] b,
  output logic           last,
  output logic [3:0]     op_q,
  output logic [TAM-1:0] res,
  output logic           carry
);

  localparam int CW = $clog2(TAM + 1);

  logic [TAM-1:0] hi, lo, b_q;
  logic [TAM-1:0] hi_n, lo_n;
  logic [CW-1:0]  cnt;
  logic [TAM:0]   sum;
  logic [TAM:0]   rem_sh;

  // One shift-add (mul) or restoring shift-subtract (div) step.
  always_comb begin
    hi_n   = hi;
    lo_n   = lo;
    sum    = '0;
    rem_sh = '0;
    if (op_q == ULA_MULL || op_q == ULA_MULH) begin
      sum  = {1'b0, hi} + (lo[0] ? {1'b0, b_q} : '0);
      hi_n = sum[TAM:1];
      lo_n = {sum[0], lo[TAM-1:1]};
    end else begin
      rem_sh = {hi, lo[TAM-1]};
      lo_n   = {lo[TAM-2:0], 1'b0};
      if (rem_sh >= {1'b0, b_q}) begin
        // true difference is below 2^TAM, so the truncated subtract is exact
        hi_n    = rem_sh[TAM-1:0] - b_q;
        lo_n[0] = 1'b1;
      end else begin
        hi_n = rem_sh[TAM-1:0];
      end
    end
  end

  // Result selection; divide by zero falls out of the restoring loop as
  // quotient all ones and remainder equal to the dividend.
  always_comb begin
    res   = '0;
    carry = 1'b0;
    case (op_q)
      ULA_MULL: res = lo_n;
      ULA_MULH: begin
        res   = hi_n;
        carry = (hi_n != '0);
      end
      ULA_DIVU: begin
        res   = lo_n;
        carry = (b_q == '0);
      end
      ULA_REMU: begin
        res   = hi_n;
        carry = (b_q == '0);
      end
      default: ;
    endcase
  end

  assign last = (cnt == CW'(1));

  // Operand latch on start, then TAM iteration steps.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi   <= '0;
      lo   <= '0;
      b_q  <= '0;
      op_q <= '0;
      cnt  <= '0;
    end else if (start) begin
      hi   <= '0;
      lo   <= a;
      b_q  <= b;
      op_q <= op;
      cnt  <= CW'(TAM);
    end else if (cnt != '0) begin
      hi  <= hi_n;
      lo  <= lo_n;
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/nrisc_ula_seq.sv
// Registered NRISC ALU with valid/ready handshakes on both sides.
// Define NRISC_ULA_MULDIV_EN to build the multi-cycle mul/div/rem engine;
// otherwise opcodes 11-14 behave as reserved single-cycle ops.
module nrisc_ula_seq
  import nrisc_ula_seq_pkg::*;
#(
  parameter int TAM = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ULA_in_valid,
  output logic           ULA_in_ready,
  input  logic [TAM-1:0] ULA_A,
  input  logic [TAM-1:0] ULA_B,
  input  logic [3:0]     ULA_ctrl,
  output logic           ULA_out_valid,
  input  logic           ULA_out_ready,
  output logic [TAM-1:0] ULA_OUT,
  output logic [2:0]     ULA_flags
);

  localparam int SHW = $clog2(TAM);

  ula_state_t     state, state_n;
  logic           accept;
  logic           load_sc;
  logic [TAM-1:0] sc_res;
  logic           sc_c;
  logic [SHW-1:0] sh, sh_m1;
  logic [SHW:0]   inv_sh;
  logic           r_out, l_out;

`ifdef NRISC_ULA_MULDIV_EN
  logic           md_start, md_last, md_carry, load_md;
  logic [3:0]     md_op;
  logic [TAM-1:0] md_res;

  nrisc_ula_muldiv #(.TAM(TAM)) u_muldiv (
    .clk   (clk),
    .rst   (rst),
    .start (md_start),
    .op    (ULA_ctrl),
    .a     (ULA_A),
    .b     (ULA_B),
    .last  (md_last),
    .op_q  (md_op),
    .res   (md_res),
    .carry (md_carry)
  );

  assign ULA_in_ready = (state == ST_IDLE) || ((state == ST_DONE) && ULA_out_ready);
`else
  assign ULA_in_ready = (state == ST_IDLE) || ULA_out_ready;
`endif

  assign accept        = ULA_in_valid && ULA_in_ready;
  assign ULA_out_valid = (state == ST_DONE);

  // Single-cycle datapath: logic, add/sub and width-generic shifts/rotates.
  always_comb begin
    sh     = ULA_B[SHW-1:0];
    sh_m1  = sh - 1'b1;
    inv_sh = (SHW+1)'(TAM) - {1'b0, sh};
    // bit that leaves last: A[sh-1] for right moves, A[TAM-sh] for left moves
    r_out  = (sh != '0) && (|(ULA_A & (TAM'(1) << sh_m1)));
    l_out  = (sh != '0) && (|(ULA_A & (TAM'(1) << inv_sh)));
    sc_res = '0;
    sc_c   = 1'b0;
    case (ULA_ctrl)
      ULA_ADD:  {sc_c, sc_res} = {1'b0, ULA_A} + {1'b0, ULA_B};
      ULA_SUB: begin
        sc_res = ULA_A - ULA_B;
        sc_c   = (ULA_A >= ULA_B);
      end
      ULA_AND:  sc_res = ULA_A & ULA_B;
      ULA_NAND: sc_res = ~(ULA_A & ULA_B);
      ULA_OR:   sc_res = ULA_A | ULA_B;
      ULA_XOR:  sc_res = ULA_A ^ ULA_B;
      ULA_SHR: begin
        sc_res = ULA_A >> sh;
        sc_c   = r_out;
      end
      ULA_ROTR: begin
        sc_res = (ULA_A >> sh) | (ULA_A << inv_sh);
        sc_c   = r_out;
      end
      ULA_SAR: begin
        sc_res = TAM'($signed(ULA_A) >>> sh);
        sc_c   = r_out;
      end
      ULA_SHL: begin
        sc_res = ULA_A << sh;
        sc_c   = l_out;
      end
      ULA_ROTL: begin
        sc_res = (ULA_A << sh) | (ULA_A >> inv_sh);
        sc_c   = l_out;
      end
      default: ;
    endcase
  end

  // Next-state and issue decode; a new command may be dispatched from IDLE or
  // from DONE in the same cycle the pending result is taken.
  always_comb begin
    state_n = state;
    load_sc = 1'b0;
`ifdef NRISC_ULA_MULDIV_EN
    md_start = 1'b0;
    load_md  = 1'b0;
`endif
    case (state)
      ST_IDLE: ;
      ST_BUSY: begin
`ifdef NRISC_ULA_MULDIV_EN
        if (md_last) begin
          load_md = 1'b1;
          state_n = ST_DONE;
        end
`else
        state_n = ST_IDLE;
`endif
      end
      ST_DONE: if (ULA_out_ready) state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
    if (accept) begin
`ifdef NRISC_ULA_MULDIV_EN
      if (is_muldiv(ULA_ctrl)) begin
        md_start = 1'b1;
        state_n  = ST_BUSY;
      end else begin
        load_sc = 1'b1;
        state_n = ST_DONE;
      end
`else
      load_sc = 1'b1;
      state_n = ST_DONE;
`endif
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  // Result and flag registers, held while DONE waits for the consumer.
  always_ff @(posedge clk) begin
    if (rst) begin
      ULA_OUT   <= '0;
      ULA_flags <= 3'b010;
    end else if (load_sc) begin
      ULA_OUT               <= sc_res;
      ULA_flags[FLAG_MINUS] <= minus_op(ULA_ctrl) && sc_res[TAM-1];
      ULA_flags[FLAG_ZERO]  <= (sc_res == '0);
      ULA_flags[FLAG_CARRY] <= sc_c;
    end
`ifdef NRISC_ULA_MULDIV_EN
    else if (load_md) begin
      ULA_OUT               <= md_res;
      ULA_flags[FLAG_MINUS] <= minus_op(md_op) && md_res[TAM-1];
      ULA_flags[FLAG_ZERO]  <= (md_res == '0);
      ULA_flags[FLAG_CARRY] <= md_carry;
    end
`endif
  end

endmodule

// File: tb/tb_nrisc_ula_seq.sv
// Self-checking bench for nrisc_ula_seq (TAM=32). Expectations follow the
// NRISC_ULA_MULDIV_EN setting of the build.
module tb_nrisc_ula_seq;

  localparam int TAM = 32;
`ifdef NRISC_ULA_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ULA_in_valid = 1'b0;
  logic        ULA_in_ready;
  logic [31:0] ULA_A = '0;
  logic [31:0] ULA_B = '0;
  logic [3:0]  ULA_ctrl = '0;
  logic        ULA_out_valid;
  logic        ULA_out_ready = 1'b1;
  logic [31:0] ULA_OUT;
  logic [2:0]  ULA_flags;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int bp_mode = 0;   // 0: always ready, 1: random, 2: never ready

  nrisc_ula_seq #(.TAM(TAM)) dut (
    .clk           (clk),
    .rst           (rst),
    .ULA_in_valid  (ULA_in_valid),
    .ULA_in_ready  (ULA_in_ready),
    .ULA_A         (ULA_A),
    .ULA_B         (ULA_B),
    .ULA_ctrl      (ULA_ctrl),
    .ULA_out_valid (ULA_out_valid),
    .ULA_out_ready (ULA_out_ready),
    .ULA_OUT       (ULA_OUT),
    .ULA_flags     (ULA_flags)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (bp_mode)
      0:       ULA_out_ready = 1'b1;
      1:       ULA_out_ready = ($urandom_range(0, 3) != 0);
      default: ULA_out_ready = 1'b0;
    endcase
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: {minus, zero, carry, result} straight from the opcode rules.
  function automatic logic [34:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic        c;
    logic [63:0] d, p;
    int          n;
    n = int'(b[4:0]);
    d = {a, a};
    p = 64'(a) * 64'(b);
    r = '0;
    c = 1'b0;
    case (op)
      4'd0: begin p = 64'(a) + 64'(b); r = p[31:0]; c = p[32]; end
      4'd1: begin r = a - b; c = (a >= b); end
      4'd2: r = a & b;
      4'd3: r = ~(a & b);
      4'd4: r = a | b;
      4'd5: r = a ^ b;
      4'd6: begin r = a >> n; c = (n == 0) ? 1'b0 : a[n-1]; end
      4'd7: begin d = d >> n; r = d[31:0]; c = (n == 0) ? 1'b0 : a[n-1]; end
      4'd8: begin r = $signed(a) >>> n; c = (n == 0) ? 1'b0 : a[n-1]; end
      4'd9: begin r = a << n; c = (n == 0) ? 1'b0 : a[32-n]; end
      4'd10: begin d = d << n; r = d[63:32]; c = (n == 0) ? 1'b0 : a[32-n]; end
      4'd11: if (MD) r = p[31:0];
      4'd12: if (MD) begin r = p[63:32]; c = (r != 0); end
      4'd13: if (MD) begin
        if (b == 0) begin r = '1; c = 1'b1; end
        else r = a / b;
      end
      4'd14: if (MD) begin
        if (b == 0) begin r = a; c = 1'b1; end
        else r = a % b;
      end
      default: ;
    endcase
    return {((op == 4'd0 || op == 4'd1 || op == 4'd8 || op == 4'd11) && r[31]), (r == 0), c, r};
  endfunction

  typedef struct {
    logic [31:0] r;
    logic [2:0]  f;
    int          acc;
    int          lat;
  } exp_t;
  exp_t q[$];

  // Cycle-by-cycle compare against the transaction model.
  always @(negedge clk) begin
    logic [34:0] m;
    logic        vis;
    logic        exp_rdy;
    exp_t        e;
    if (rst) begin
      q.delete();
    end else begin
      vis = (q.size() > 0) && (cyc >= q[0].acc + q[0].lat);
      exp_rdy = (q.size() == 0) ? 1'b1 : (vis ? ULA_out_ready : 1'b0);
      chk("out_valid", ULA_out_valid, vis);
      chk("in_ready", ULA_in_ready, exp_rdy);
      if (vis && ULA_out_valid) begin
        chk("result", ULA_OUT, q[0].r);
        chk("flags", ULA_flags, q[0].f);
        if (ULA_out_ready) void'(q.pop_front());
      end
      if (ULA_in_valid && exp_rdy) begin
        m = model(ULA_ctrl, ULA_A, ULA_B);
        e.r = m[31:0];
        e.f = m[34:32];
        e.acc = cyc;
        e.lat = (MD && ULA_ctrl >= 4'd11 && ULA_ctrl <= 4'd14) ? TAM + 1 : 1;
        q.push_back(e);
      end
    end
  end

  // Present a command (called at posedge+1) and hold it until accepted.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic got;
    got = 1'b0;
    ULA_in_valid = 1'b1;
    ULA_ctrl = op;
    ULA_A = a;
    ULA_B = b;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (ULA_in_ready) got = 1'b1;
      @(posedge clk);
      #1;
    end
    ULA_in_valid = 1'b0;
    chk("issue_accepted", got, 1'b1);
  endtask

  task automatic run_lit(input string name, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] er, input logic [2:0] ef);
    issue(op, a, b);
    for (int i = 0; i < 100 && !ULA_out_valid; i++) @(negedge clk);
    chk({name, "_valid"}, ULA_out_valid, 1'b1);
    chk({name, "_out"}, ULA_OUT, er);
    chk({name, "_flags"}, ULA_flags, ef);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0]  op;
    logic [31:0] a, b;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", ULA_out_valid, 1'b0);
    chk("reset_out", ULA_OUT, 32'h0);
    chk("reset_flags", ULA_flags, 3'b010);
    chk("reset_in_ready", ULA_in_ready, 1'b1);
    @(posedge clk);
    #1;

    run_lit("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'h1, 32'h0, 3'b011);
    run_lit("sub_neg", 4'd1, 32'd5, 32'd7, 32'hFFFF_FFFE, 3'b100);
    run_lit("sub_pos", 4'd1, 32'd7, 32'd5, 32'd2, 3'b001);
    run_lit("rotl_1", 4'd10, 32'h8000_0001, 32'h21, 32'h3, 3'b001);
    run_lit("sar_31", 4'd8, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 3'b100);
    run_lit("rotr_0", 4'd7, 32'h1, 32'h40, 32'h1, 3'b000);
    run_lit("shl_1", 4'd9, 32'h8000_0001, 32'h1, 32'h2, 3'b001);
    run_lit("rsvd", 4'd15, 32'h1234, 32'h5, 32'h0, 3'b010);
    run_lit("mull", 4'd11, 32'h1_0000, 32'h1_0000, 32'h0, 3'b010);
`ifdef NRISC_ULA_MULDIV_EN
    run_lit("mulh", 4'd12, 32'h1_0000, 32'h1_0000, 32'h1, 3'b001);
    run_lit("divu_0", 4'd13, 32'd100, 32'd0, 32'hFFFF_FFFF, 3'b001);
    run_lit("remu_0", 4'd14, 32'd100, 32'd0, 32'd100, 3'b001);
    run_lit("divu_7", 4'd13, 32'd100, 32'd7, 32'd14, 3'b000);
`else
    run_lit("mulh", 4'd12, 32'h1_0000, 32'h1_0000, 32'h0, 3'b010);
    run_lit("divu_0", 4'd13, 32'd100, 32'd0, 32'h0, 3'b010);
    run_lit("remu_0", 4'd14, 32'd100, 32'd0, 32'h0, 3'b010);
    run_lit("divu_7", 4'd13, 32'd100, 32'd7, 32'h0, 3'b010);
`endif

    // Backpressure: result must hold while the consumer stalls.
    bp_mode = 2;
    repeat (2) @(posedge clk);
    #1;
    issue(4'd0, 32'd3, 32'd4);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", ULA_out_valid, 1'b1);
      chk("bp_out", ULA_OUT, 32'd7);
      chk("bp_flags", ULA_flags, 3'b000);
      chk("bp_in_ready", ULA_in_ready, 1'b0);
    end
    bp_mode = 0;
    repeat (2) @(posedge clk);
    #1;

    // Reset while a long operation is pending.
    bp_mode = 2;
    issue(4'd11, 32'd5, 32'd6);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_out_valid", ULA_out_valid, 1'b0);
    rst = 1'b0;
    bp_mode = 0;
    @(negedge clk);
    chk("midrst_in_ready", ULA_in_ready, 1'b1);
    chk("midrst_valid_after", ULA_out_valid, 1'b0);
    @(posedge clk);
    #1;

    // Randomized traffic with random consumer stalls.
    bp_mode = 1;
    for (int n = 0; n < 250; n++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      op = 4'($urandom_range(0, 15));
      a = $urandom;
      if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 300);
      case ($urandom_range(0, 3))
        0:       b = '0;
        1:       b = $urandom_range(0, 40);
        default: b = $urandom;
      endcase
      issue(op, a, b);
    end

    bp_mode = 0;
    for (int i = 0; i < 200 && q.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain", q.size(), 0);
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #900000;
    n_bad++;
    $display("FAIL watchdog: got timeout expected finish (cycle %0d)", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
